// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-subset core (addu/subu/jr/ori/lui/lw/sw/beq/j/jal)
// with req/ready handshakes to external instruction and data memories.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        hang
);

  typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, a_q, b_q, r_q;
  logic [31:0] gpr [32];
  logic [31:0] wait_q;
  logic        hang_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, pc_plus4, alu_out;
  logic        is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic        xfer_wait;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign pc_plus4 = pc_q + 32'd4;

  assign is_addu = (op == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);

  assign dst = is_jal ? 5'd31 : ((op == OP_RTYPE) ? rd : rt);

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign dmem_addr  = r_q;
  assign dmem_wdata = b_q;
  assign hang       = hang_q;

  assign xfer_wait = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);

  // ALU: arithmetic, immediates and load/store effective address
  always_comb begin
    alu_out = '0;
    if (is_addu)           alu_out = a_q + b_q;
    else if (is_subu)      alu_out = a_q - b_q;
    else if (is_ori)       alu_out = a_q | imm_zext;
    else if (is_lui)       alu_out = {imm, 16'h0000};
    else if (is_lw || is_sw) alu_out = a_q + imm_sext;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state, handshake strobes, retire/write-back and next PC
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = DECODE;
      end
      DECODE: state_d = EXE;
      EXE: begin
        if (is_lw || is_sw) begin
          state_d = MEM;
        end else if (is_addu || is_subu || is_ori || is_lui) begin
          state_d = WB;
        end else begin
          // control transfers and unrecognised encodings all finish here
          retire  = 1'b1;
          state_d = FETCH;
          if (is_beq)             pc_d = (a_q == b_q) ? pc_plus4 + {imm_sext[29:0], 2'b00} : pc_plus4;
          else if (is_j || is_jal) pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
          else if (is_jr)         pc_d = a_q;
          else                    pc_d = pc_plus4;
          if (is_jal) begin
            wb_we   = 1'b1;
            wb_addr = 5'd31;
            wb_data = pc_plus4;
          end
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            pc_d    = pc_plus4;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        wb_we   = 1'b1;
        wb_addr = dst;
        wb_data = r_q;
        retire  = 1'b1;
        pc_d    = pc_plus4;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // PC and instruction/operand/result latches
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      r_q  <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        FETCH:  if (imem_ready) ir_q <= imem_rdata;
        DECODE: begin
          a_q <= gpr[rs];
          b_q <= gpr[rt];
        end
        EXE:    r_q <= alu_out;
        MEM:    if (dmem_ready && !is_sw) r_q <= dmem_rdata;
        default: ;
      endcase
    end
  end

  // Register file; $0 is never written so it always reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) gpr[i[4:0]] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      gpr[wb_addr] <= wb_data;
    end
  end

  // Per-transfer wait counter and sticky hang flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      hang_q <= 1'b0;
    end else if (xfer_wait) begin
      if (wait_q != '1) wait_q <= wait_q + 32'd1;
      if ((MAX_WAIT != 0) && (wait_q >= MAX_WAIT)) hang_q <= 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed tests for mc_datapath with simple req/ready memory models.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic        retire, wb_we, hang;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15] = '{5: 32'hdead_beef, default: 32'h0};
  logic        imem_hold = 1'b0;
  logic        dmem_hold = 1'b0;
  int          dmem_delay = 0;
  int          dcnt = 0;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  mc_datapath #(.RESET_PC(32'h0000_3000), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .retire(retire), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .hang(hang)
  );

  always #5 clk = ~clk;

  // Memory responders
  assign imem_rdata = imem[imem_addr[7:2]];
  assign imem_ready = imem_req && !imem_hold;
  assign dmem_rdata = dmem[dmem_addr[5:2]];
  assign dmem_ready = dmem_req && !dmem_hold && (dcnt >= dmem_delay);

  always @(posedge clk) begin
    if (rst || !(dmem_req && !dmem_ready)) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end

  always @(posedge clk) begin
    if (!rst && dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[5:2]] <= dmem_wdata;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic step();
    @(negedge clk);
    cycle++;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  // Two rising edges with rst high; returns in the first FETCH cycle (cycle 1)
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle = 1;
  endtask

  // Advances until retire is seen (bounded), captures write-back, steps past it
  task automatic run_to_retire(input int limit, output bit found, output int lat,
                               output logic we, output logic [4:0] wa, output logic [31:0] wd);
    int start;
    start = cycle;
    found = 1'b0; lat = 0; we = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < limit; i++) begin
      if (retire === 1'b1) begin
        found = 1'b1;
        lat = cycle - start + 1;
        we = wb_we; wa = wb_addr; wd = wb_data;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit f; int lat; logic we; logic [4:0] wa; logic [31:0] wd;
    clear_prog();
    imem[0] = enc_i(6'h0d, 5'd0, 5'd1, 16'h1234);
    do_reset();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL reset_imem_addr: got %h want 00003000", imem_addr); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_dmem: req=%b we=%b want 0 0", dmem_req, dmem_we); end
    checks++; if (retire !== 1'b0 || wb_we !== 1'b0 || hang !== 1'b0) begin errors++; $display("FAIL reset_flags: retire=%b wb_we=%b hang=%b want 0 0 0", retire, wb_we, hang); end
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 4) begin errors++; $display("FAIL ori_latency: found=%0d lat=%0d want 4", f, lat); end
    checks++; if (we !== 1'b1 || wa !== 5'd1 || wd !== 32'h0000_1234) begin errors++; $display("FAIL ori_wb: we=%b addr=%0d data=%h want 1 1 00001234", we, wa, wd); end
  endtask

  task automatic test_arith();
    bit f; int lat; logic we; logic [4:0] wa; logic [31:0] wd;
    logic [4:0]  ea [6];
    logic [31:0] ed [6];
    clear_prog();
    imem[0] = enc_i(6'h0f, 5'd0, 5'd2, 16'hffff);   ea[0] = 5'd2; ed[0] = 32'hffff_0000;
    imem[1] = enc_i(6'h0d, 5'd2, 5'd2, 16'hffff);   ea[1] = 5'd2; ed[1] = 32'hffff_ffff;
    imem[2] = enc_r(5'd2, 5'd2, 5'd3, 6'h21);       ea[2] = 5'd3; ed[2] = 32'hffff_fffe;
    imem[3] = enc_r(5'd0, 5'd2, 5'd4, 6'h23);       ea[3] = 5'd4; ed[3] = 32'h0000_0001;
    imem[4] = enc_i(6'h0d, 5'd0, 5'd0, 16'h5555);   ea[4] = 5'd0; ed[4] = 32'h0000_5555;
    imem[5] = enc_r(5'd0, 5'd0, 5'd5, 6'h21);       ea[5] = 5'd5; ed[5] = 32'h0000_0000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_to_retire(20, f, lat, we, wa, wd);
      checks++;
      if (!f || lat != 4 || we !== 1'b1 || wa !== ea[i] || (i != 4 && wd !== ed[i])) begin
        errors++;
        $display("FAIL arith_%0d: found=%0d lat=%0d we=%b addr=%0d data=%h want lat=4 we=1 addr=%0d data=%h", i, f, lat, we, wa, wd, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_memory();
    bit f; int lat; logic we; logic [4:0] wa; logic [31:0] wd;
    clear_prog();
    imem[0] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0010);
    imem[1] = enc_i(6'h23, 5'd1, 5'd2, 16'h0004);
    imem[2] = enc_i(6'h2b, 5'd1, 5'd2, 16'h0008);
    dmem_delay = 3;
    do_reset();
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 4) begin errors++; $display("FAIL mem_base_ori: found=%0d lat=%0d want 4", f, lat); end
    step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h14 || imem_req !== 1'b0 || retire !== 1'b0) begin
        errors++;
        $display("FAIL lw_mem_hold_%0d: req=%b we=%b addr=%h ireq=%b retire=%b want 1 0 00000014 0 0", k, dmem_req, dmem_we, dmem_addr, imem_req, retire);
      end
      step();
    end
    checks++;
    if (retire !== 1'b1 || wb_we !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 32'hdead_beef) begin
      errors++;
      $display("FAIL lw_wb: retire=%b we=%b addr=%0d data=%h want 1 1 2 deadbeef", retire, wb_we, wb_addr, wb_data);
    end
    step();
    dmem_delay = 0;
    step(); step(); step();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h18 || dmem_wdata !== 32'hdead_beef || retire !== 1'b1) begin
      errors++;
      $display("FAIL sw_mem: req=%b we=%b addr=%h wdata=%h retire=%b want 1 1 00000018 deadbeef 1", dmem_req, dmem_we, dmem_addr, dmem_wdata, retire);
    end
    step();
    checks++; if (dmem[6] !== 32'hdead_beef) begin errors++; $display("FAIL sw_stored: got %h want deadbeef", dmem[6]); end
    checks++; if (imem_addr !== 32'h300c) begin errors++; $display("FAIL sw_next_pc: got %h want 0000300c", imem_addr); end
  endtask

  task automatic test_control();
    bit f; int lat; logic we; logic [4:0] wa; logic [31:0] wd;
    clear_prog();
    imem[0]  = enc_i(6'h0d, 5'd0, 5'd1, 16'h0005);
    imem[1]  = enc_i(6'h0d, 5'd0, 5'd2, 16'h0005);
    imem[2]  = enc_j(6'h03, 26'h000_0c10);
    imem[3]  = enc_i(6'h04, 5'd1, 5'd2, 16'hffff);
    imem[16] = enc_i(6'h04, 5'd1, 5'd3, 16'h0001);
    imem[17] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    do_reset();
    run_to_retire(20, f, lat, we, wa, wd);
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 4 || wd !== 32'h5) begin errors++; $display("FAIL ctl_setup: found=%0d lat=%0d data=%h want 4 00000005", f, lat, wd); end
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 3 || we !== 1'b1 || wa !== 5'd31 || wd !== 32'h300c) begin errors++; $display("FAIL jal_link: lat=%0d we=%b addr=%0d data=%h want 3 1 31 0000300c", lat, we, wa, wd); end
    checks++; if (imem_addr !== 32'h3040) begin errors++; $display("FAIL jal_target: got %h want 00003040", imem_addr); end
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 3 || we !== 1'b0 || imem_addr !== 32'h3044) begin errors++; $display("FAIL beq_not_taken: lat=%0d we=%b next=%h want 3 0 00003044", lat, we, imem_addr); end
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 3 || imem_addr !== 32'h300c) begin errors++; $display("FAIL jr_return: lat=%0d next=%h want 3 0000300c", lat, imem_addr); end
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 3 || imem_addr !== 32'h300c || pc !== 32'h300c) begin errors++; $display("FAIL beq_self_loop: lat=%0d next=%h pc=%h want 3 0000300c", lat, imem_addr, pc); end
  endtask

  task automatic test_illegal();
    clear_prog();
    imem[0] = 32'hfc00_0000;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (dmem_req !== 1'b0 || wb_we !== 1'b0 || retire !== (k == 3)) begin
        errors++;
        $display("FAIL illegal_cycle_%0d: dreq=%b wb_we=%b retire=%b want 0 0 %0d", k, dmem_req, wb_we, retire, (k == 3));
      end
      step();
    end
    checks++; if (imem_addr !== 32'h3004 || imem_req !== 1'b1) begin errors++; $display("FAIL illegal_next_pc: addr=%h req=%b want 00003004 1", imem_addr, imem_req); end
  endtask

  task automatic test_hang_reset();
    bit f; int lat; logic we; logic [4:0] wa; logic [31:0] wd;
    clear_prog();
    imem[0] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0010);
    imem[1] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);
    imem_hold = 1'b1;
    dmem_hold = 1'b1;
    dmem_delay = 0;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL hang_fetch_hold_%0d: req=%b addr=%h want 1 00003000", k, imem_req, imem_addr); end
      if (k == 4) begin
        checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_early: got %b want 0", hang); end
      end
      step();
    end
    checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_set: got %b want 1", hang); end
    imem_hold = 1'b0;
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 4 || hang !== 1'b1) begin errors++; $display("FAIL hang_sticky: found=%0d lat=%0d hang=%b want 4 1", f, lat, hang); end
    step(); step(); step();
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h10) begin errors++; $display("FAIL hang_lw_pending: req=%b addr=%h want 1 00000010", dmem_req, dmem_addr); end
    rst = 1'b1;
    dmem_hold = 1'b0;
    step();
    checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000 || hang !== 1'b0 || retire !== 1'b0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mem: dreq=%b ireq=%b addr=%h hang=%b retire=%b wb_we=%b want 0 1 00003000 0 0 0", dmem_req, imem_req, imem_addr, hang, retire, wb_we);
    end
    rst = 1'b0;
    cycle = 1;
    run_to_retire(20, f, lat, we, wa, wd);
    checks++; if (!f || lat != 4 || wa !== 5'd1 || wd !== 32'h10) begin errors++; $display("FAIL after_reset_ori: lat=%0d addr=%0d data=%h want 4 1 00000010", lat, wa, wd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_memory();
    test_control();
    test_illegal();
    test_hang_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
